// File: rtl/register_file_if.sv
// Writeback/decode bus of the architectural register file.
// The WB stage and decode (plus the PC value from fetch) sit on the master side.
// The register file is the slave side.
interface register_file_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  reg_write_enable;
  logic [3:0]            write_reg_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [3:0]            rn_addr;
  logic [3:0]            rm_addr;
  logic [3:0]            rs_addr;
  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] rn_data;
  logic [DATA_WIDTH-1:0] rm_data;
  logic [DATA_WIDTH-1:0] rs_data;
  logic                  pc_write_valid;
  logic [DATA_WIDTH-1:0] pc_write_data;

  modport master (
    output reg_write_enable, write_reg_addr, write_data,
    output rn_addr, rm_addr, rs_addr, pc_in,
    input  rn_data, rm_data, rs_data, pc_write_valid, pc_write_data
  );

  modport slave (
    input  reg_write_enable, write_reg_addr, write_data,
    input  rn_addr, rm_addr, rs_addr, pc_in,
    output rn_data, rm_data, rs_data, pc_write_valid, pc_write_data
  );
endinterface

// File: rtl/register_file.sv
// ARM-style 16-entry register file: R0-R14 are stored, and R15 reads return pc_in.
// A write to R15 becomes a registered one-cycle PC-write request to fetch.
// Optional macro REGFILE_WRITE_BYPASS_EN: the same-cycle WB write to R0-R14
// is forwarded to any read port that addresses the same register.
module register_file #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  register_file_if.slave        io_bus
);

  localparam logic [3:0] PC_IDX = 4'd15;

  logic [DATA_WIDTH-1:0] r_regs [0:14];
  logic                  r_pc_write_valid;
  logic [DATA_WIDTH-1:0] r_pc_write_data;

  logic                  w_wr_gpr;
  logic                  w_wr_pc;
  logic [3:0]            w_rd_addr [0:2];
  logic [DATA_WIDTH-1:0] w_rd_data [0:2];

  // The enable is evaluated first, so an X write address with the enable low
  // resolves to "no write".
  assign w_wr_gpr = io_bus.reg_write_enable && (io_bus.write_reg_addr != PC_IDX);
  assign w_wr_pc  = io_bus.reg_write_enable && (io_bus.write_reg_addr == PC_IDX);

`ifdef REGFILE_WRITE_BYPASS_EN
  logic w_byp_en;
  // Only a live (non-reset) write to R0-R14 can be forwarded.
  // A read address that matches it is therefore never 15.
  assign w_byp_en = w_wr_gpr && !reset;
`endif

  assign w_rd_addr[0] = io_bus.rn_addr;
  assign w_rd_addr[1] = io_bus.rm_addr;
  assign w_rd_addr[2] = io_bus.rs_addr;

  // State update: register writes, PC-write request, synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so that every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: this array is reset element by element on purpose. Software expects
      // R0-R14 to hold a known value after reset, so this storage has to be
      // flops and cannot be RAM.
      for (int i = 0; i < 15; i++) r_regs[i] <= RESET_VALUE;
      r_pc_write_valid <= 1'b0;
      r_pc_write_data  <= '0;
    end else begin
      r_pc_write_valid <= w_wr_pc;
      if (w_wr_pc)  r_pc_write_data <= io_bus.write_data;
      if (w_wr_gpr) r_regs[io_bus.write_reg_addr] <= io_bus.write_data;
    end
  end

  // Combinational read ports: R15 comes from pc_in, and the others come from storage (or the bypass)
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      // NOTE: a default assigned first on every path keeps this block free of latches.
      w_rd_data[p] = io_bus.pc_in;
      if (w_rd_addr[p] != PC_IDX) w_rd_data[p] = r_regs[w_rd_addr[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (w_byp_en && (w_rd_addr[p] == io_bus.write_reg_addr)) w_rd_data[p] = io_bus.write_data;
`endif
    end
  end

  assign io_bus.rn_data        = w_rd_data[0];
  assign io_bus.rm_data        = w_rd_data[1];
  assign io_bus.rs_data        = w_rd_data[2];
  assign io_bus.pc_write_valid = r_pc_write_valid;
  assign io_bus.pc_write_data  = r_pc_write_data;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. It runs directed literal checks from the
// test plan and then randomized traffic. A comparison process checks every
// falling edge against an array-based behavioural model.
module tb_register_file;

  localparam int DW = 32;

  logic clk;
  logic reset;

  register_file_if #(.DATA_WIDTH(DW)) bus ();

  register_file #(.DATA_WIDTH(DW), .RESET_VALUE('0)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: architectural registers plus the pending PC-write request
  logic [DW-1:0] m_regs [0:14];
  logic          m_pc_valid;
  logic [DW-1:0] m_pc_data;
  bit            armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] <= '0;
      m_pc_valid <= 1'b0;
      m_pc_data  <= '0;
      armed      <= 1'b1;
    end else begin
      m_pc_valid <= 1'b0;
      if (bus.reg_write_enable === 1'b1) begin
        if (bus.write_reg_addr == 4'd15) begin
          m_pc_valid <= 1'b1;
          m_pc_data  <= bus.write_data;
        end else begin
          m_regs[bus.write_reg_addr] <= bus.write_data;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [3:0] a);
    if (a == 4'd15) return bus.pc_in;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.reg_write_enable === 1'b1 && !reset && bus.write_reg_addr === a) return bus.write_data;
`endif
    return m_regs[a];
  endfunction

  // Compare process: every cycle, once the model is known
  always @(negedge clk) begin
    if (armed) begin
      check("rn_data",        bus.rn_data,                 exp_read(bus.rn_addr));
      check("rm_data",        bus.rm_data,                 exp_read(bus.rm_addr));
      check("rs_data",        bus.rs_data,                 exp_read(bus.rs_addr));
      check("pc_write_valid", {{(DW-1){1'b0}}, bus.pc_write_valid}, {{(DW-1){1'b0}}, m_pc_valid});
      check("pc_write_data",  bus.pc_write_data,           m_pc_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [DW-1:0] wd,
                       input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs);
    bus.reg_write_enable = we;
    bus.write_reg_addr   = wa;
    bus.write_data       = wd;
    bus.rn_addr          = rn;
    bus.rm_addr          = rm;
    bus.rs_addr          = rs;
  endtask

  logic [DW-1:0] lit_pcv;

  initial begin
    reset     = 1'b1;
    bus.pc_in = '0;
    drive(1'b0, 4'd0, '0, 4'd0, 4'd0, 4'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state: R0-R14 read 0 on all three ports
    for (int a = 0; a < 15; a++) begin
      drive(1'b0, 4'd0, '0, 4'(a), 4'(a), 4'(a));
      @(negedge clk);
      check("lit_reset_rn", bus.rn_data, 32'h0);
      check("lit_reset_rm", bus.rm_data, 32'h0);
      check("lit_reset_rs", bus.rs_data, 32'h0);
      tick();
    end
    lit_pcv = {31'b0, bus.pc_write_valid};
    check("lit_reset_pcv", lit_pcv, 32'h0);

    // R3 write, readable next cycle on all ports; neighbours untouched
    drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, '0, 4'd3, 4'd3, 4'd3);
    @(negedge clk);
    check("lit_r3_rn", bus.rn_data, 32'hDEAD_BEEF);
    check("lit_r3_rm", bus.rm_data, 32'hDEAD_BEEF);
    check("lit_r3_rs", bus.rs_data, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 4'd0, '0, 4'd2, 4'd4, 4'd2);
    @(negedge clk);
    check("lit_r2", bus.rn_data, 32'h0);
    check("lit_r4", bus.rm_data, 32'h0);
    tick();

    // Same-cycle write/read of R5
    drive(1'b1, 4'd5, 32'h1234_5678, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("lit_r5_same", bus.rn_data, 32'h1234_5678);
`else
    check("lit_r5_same", bus.rn_data, 32'h0);
`endif
    tick();
    drive(1'b0, 4'd0, '0, 4'd5, 4'd0, 4'd0);
    @(negedge clk);
    check("lit_r5_next", bus.rn_data, 32'h1234_5678);
    tick();

    // R15 write becomes a one-cycle PC-write request; R15 reads give pc_in
    bus.pc_in = 32'h0000_0108;
    drive(1'b1, 4'd15, 32'h0000_0400, 4'd15, 4'd3, 4'd5);
    @(negedge clk);
    check("lit_r15_read", bus.rn_data, 32'h0000_0108);
    tick();
    drive(1'b0, 4'd0, '0, 4'd15, 4'd3, 4'd5);
    @(negedge clk);
    lit_pcv = {31'b0, bus.pc_write_valid};
    check("lit_pcv_hi",   lit_pcv,           32'h1);
    check("lit_pcd",      bus.pc_write_data, 32'h0000_0400);
    check("lit_r3_keep",  bus.rm_data,       32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    lit_pcv = {31'b0, bus.pc_write_valid};
    check("lit_pcv_lo",   lit_pcv,           32'h0);
    check("lit_pcd_hold", bus.pc_write_data, 32'h0000_0400);
    tick();

    // Back-to-back R15 writes
    drive(1'b1, 4'd15, 32'h0000_0500, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd15, 32'h0000_0600, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    lit_pcv = {31'b0, bus.pc_write_valid};
    check("lit_b2b_pcv0", lit_pcv,           32'h1);
    check("lit_b2b_pcd0", bus.pc_write_data, 32'h0000_0500);
    tick();
    drive(1'b0, 4'd0, '0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    lit_pcv = {31'b0, bus.pc_write_valid};
    check("lit_b2b_pcv1", lit_pcv,           32'h1);
    check("lit_b2b_pcd1", bus.pc_write_data, 32'h0000_0600);
    tick();

    // Disabled write leaves R7 unchanged; an X write address with the enable low is harmless
    drive(1'b1, 4'd7, 32'h0000_0077, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd7, 32'hFFFF_FFFF, 4'd7, 4'd7, 4'd7);
    tick();
    drive(1'b0, 4'd7, 32'hFFFF_FFFF, 4'd7, 4'd0, 4'd0);
    bus.write_reg_addr = 4'bxxxx;
    @(negedge clk);
    check("lit_r7_hold", bus.rn_data, 32'h0000_0077);
    tick();

    // Reset together with an R15 write: the write is dropped
    drive(1'b1, 4'd1, 32'hAAAA_AAAA, 4'd0, 4'd0, 4'd0);
    tick();
    reset = 1'b1;
    drive(1'b1, 4'd15, 32'h0000_0100, 4'd1, 4'd0, 4'd0);
    @(negedge clk);
    check("lit_r1_before_rst", bus.rn_data, 32'hAAAA_AAAA);
    tick();
    reset = 1'b0;
    drive(1'b0, 4'd0, '0, 4'd1, 4'd0, 4'd0);
    @(negedge clk);
    lit_pcv = {31'b0, bus.pc_write_valid};
    check("lit_r1_after_rst", bus.rn_data, 32'h0);
    check("lit_rst_pcv",      lit_pcv,     32'h0);
    tick();

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] wa;
      logic [3:0] ra [3];
      reset = ($urandom_range(0, 99) == 0);
      wa    = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      bus.pc_in = $urandom;
      drive(1'($urandom_range(0, 1)), wa, $urandom, ra[0], ra[1], ra[2]);
      tick();
    end

    reset = 1'b0;
    drive(1'b0, 4'd0, '0, 4'd0, 4'd0, 4'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- ARM-style 16-entry architectural register file. It is the consumer end of the writeback interface: it accepts write_data, write_reg_addr and reg_write_enable from the WB stage.
- Three combinational read ports (Rn, Rm, Rs) feed the decode stage.
- R15 is not stored. Reads of R15 return the PC value supplied by fetch. Writes to R15 are turned into a registered one-cycle PC-write request to fetch.

Parameters:
- DATA_WIDTH, 32, width of every register and data port.
- RESET_VALUE, 32'h0000_0000, value loaded into R0-R14 on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_write_enable  input  1  write strobe from WB stage.
- write_reg_addr  input  4  destination register index from WB stage.
- write_data  input  DATA_WIDTH  data to write, from WB stage.
- rn_addr  input  4  read port A index.
- rm_addr  input  4  read port B index.
- rs_addr  input  4  read port C index (shift register / store data).
- pc_in  input  DATA_WIDTH  PC+8 value from fetch, returned for R15 reads.
- rn_data  output  DATA_WIDTH  read port A data.
- rm_data  output  DATA_WIDTH  read port B data.
- rs_data  output  DATA_WIDTH  read port C data.
- pc_write_valid  output  1  one-cycle pulse: WB wrote R15.
- pc_write_data  output  DATA_WIDTH  target PC accompanying pc_write_valid.

Behaviour:
- Storage: 15 registers, R0-R14, each DATA_WIDTH bits. There is no R15 storage.
- Reset (synchronous, clk edge with reset=1):
  - R0-R14 load RESET_VALUE.
  - pc_write_valid=0, pc_write_data=0.
  - Any write presented in the reset cycle is discarded, including a write to R15.
- Write, rising edge with reset=0 and reg_write_enable=1:
  - Address 0-14: that register loads write_data. Latency 1 cycle; visible on read ports from the next cycle (see optional feature for same-cycle visibility).
  - Address 15: no register changes. Next cycle pc_write_valid=1 and pc_write_data=write_data.
- reg_write_enable=0: no register changes.
- pc_write_valid and pc_write_data are registered:
  - pc_write_valid is high for exactly one cycle per R15 write.
  - Back-to-back R15 writes hold pc_write_valid high on consecutive cycles, each cycle carrying its own data.
  - pc_write_data holds its last value when pc_write_valid=0.
- Reads are purely combinational from the address:
  - Index 0-14 returns the stored value.
  - Index 15 returns pc_in, regardless of any pending or same-cycle R15 write.
- Any combination of the three read addresses is legal, including all equal.
- write_reg_addr is ignored when reg_write_enable=0, so X on it is tolerated.
- A read port whose address is X may output X. No other output may go X after reset.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: write-through bypass. The condition is reg_write_enable=1, reset=0, write_reg_addr in 0-14, and a read address equal to write_reg_addr. When it holds, that read port returns write_data in the same cycle instead of the stored value. This lets a WB write and an ID read of the same register resolve in one cycle. R15 reads are never bypassed.
- Undefined: no bypass. Read ports always return the stored value, i.e. the old value during the write cycle. The hazard unit must stall one extra cycle.

Test Plan:
- Reset, then read all of R0-R14 on rn/rm/rs -> every port returns 0x0000_0000; pc_write_valid=0.
- Write R3=0xDEAD_BEEF with reg_write_enable=1; next cycle set rn=3, rm=3, rs=3 -> all three return 0xDEAD_BEEF. R2 and R4 still read 0.
- Write R5=0x1234_5678 and read rn=5 in the same cycle -> with REGFILE_WRITE_BYPASS_EN, rn_data=0x1234_5678 that cycle. Without it, rn_data=0 that cycle and 0x1234_5678 the next.
- pc_in=0x0000_0108, write R15=0x0000_0400 -> no R0-R14 change; rn=15 reads 0x0000_0108; next cycle pc_write_valid=1, pc_write_data=0x0000_0400; the cycle after, pc_write_valid=0.
- reg_write_enable=0 with write_reg_addr=7 and write_data=0xFFFF_FFFF -> R7 stays at its prior value.
- Load R1=0xAAAA_AAAA, then assert reset together with a write R15=0x100 -> next cycle R1 reads 0 and pc_write_valid=0.
